// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants and helpers for the VGA raster timing source.
//   - axis_timing_t    : display/front/sync/back lengths of one axis
//   - VGA640_* / SVGA800_* : 640x480@60 (25.175 MHz) and 800x600@60 (40 MHz)
//   - axis_total()     : sum of the four segment lengths of an axis
//   - count_width()    : smallest counter width able to hold 0..total-1
package vga_timing_pkg;

    typedef struct packed {
        int display;
        int front;
        int sync;
        int back;
    } axis_timing_t;

    localparam axis_timing_t VGA640_H  = '{display: 640, front: 16, sync: 96,  back: 48};
    localparam axis_timing_t VGA640_V  = '{display: 480, front: 10, sync: 2,   back: 33};
    localparam int unsigned  VGA640_PIXEL_HZ = 32'd25_175_000;

    localparam axis_timing_t SVGA800_H = '{display: 800, front: 40, sync: 128, back: 88};
    localparam axis_timing_t SVGA800_V = '{display: 600, front: 1,  sync: 4,   back: 23};
    localparam int unsigned  SVGA800_PIXEL_HZ = 32'd40_000_000;

    function automatic int axis_total(input int display, input int front,
                                      input int sync, input int back);
        return display + front + sync + back;
    endfunction

    function automatic int count_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_timing_generator_axis.sv
// timing_axis
//   Generic raster axis: a counter running 0..TOTAL-1 with sync/active decode.
//   The sync/active outputs are decoded from the *next* count so that a parent
//   can register them on the same edge the counter loads, giving zero lag.
//
//   clk_i        : pixel clock
//   rst_i        : asynchronous active-high reset, count -> 0
//   adv_i        : advance the count by one on this edge
//   restart_i    : force count to 0 on this edge (dominates adv_i)
//   count_o      : current count
//   count_next_o : value the counter loads on the next edge
//   sync_o       : sync level (POL when active) for count_next_o
//   active_o     : count_next_o lies in the display segment
//   wrap_o       : current count is the last one of the period
module timing_axis
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48,
    parameter bit POL     = 1'b0,
    parameter int W       = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         adv_i,
    input  logic         restart_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_next_o,
    output logic         sync_o,
    output logic         active_o,
    output logic         wrap_o
);

    localparam int TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);

    if (DISPLAY < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_lengths
        $fatal(1, "timing_axis: DISPLAY, FRONT, SYNC and BACK must all be >= 1");
    end

    if (TOTAL > (1 << W)) begin : g_bad_width
        $fatal(1, "timing_axis: counter width W too small for the axis period");
    end

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACTIVE_END = W'(DISPLAY);
    localparam logic [W-1:0] SYNC_FIRST = W'(DISPLAY + FRONT);
    localparam logic [W-1:0] SYNC_LAST  = W'(DISPLAY + FRONT + SYNC - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         wrap;
    logic         in_sync;

    assign wrap = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (restart_i) begin
            count_d = '0;
        end else if (adv_i) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign in_sync = (count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST);

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign sync_o       = in_sync ? POL : ~POL;
    assign active_o     = (count_d < ACTIVE_END);
    assign wrap_o       = wrap;

endmodule

// File: rtl/vga_timing_generator.sv
// vga_timing_generator
//   Two-axis VGA raster timing source built from two timing_axis instances.
//   Every output is a register loaded with the decode of the next counter
//   state, so sync/DE/strobes line up exactly with X/Y and never glitch.
//
//   clk_i         : pixel clock
//   rst_i         : asynchronous active-high reset, state -> (0,0)
//   ce_i          : pixel-rate enable; nothing changes on edges with ce_i=0
//   restart_i     : synchronous restart to (0,0), honoured only with ce_i=1
//   hsync_o       : horizontal sync, active level H_POL
//   vsync_o       : vertical sync, active level V_POL (changes only at x=0)
//   de_o          : display enable, x < H_DISPLAY and y < V_DISPLAY
//   x_o / y_o     : current raster position
//   line_start_o  : high while x == 0
//   frame_start_o : high while x == 0 and y == 0
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = VGA640_H.display,
    parameter int H_FRONT   = VGA640_H.front,
    parameter int H_SYNC    = VGA640_H.sync,
    parameter int H_BACK    = VGA640_H.back,
    parameter int V_DISPLAY = VGA640_V.display,
    parameter int V_FRONT   = VGA640_V.front,
    parameter int V_SYNC    = VGA640_V.sync,
    parameter int V_BACK    = VGA640_V.back,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int X_W       = 11,
    parameter int Y_W       = 10
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           ce_i,
    input  logic           restart_i,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           de_o,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           line_start_o,
    output logic           frame_start_o
);

    logic           restart_ce;
    logic           v_adv;
    logic [X_W-1:0] h_count;
    logic [X_W-1:0] h_next;
    logic [Y_W-1:0] v_count;
    logic [Y_W-1:0] v_next;
    logic           h_sync;
    logic           v_sync;
    logic           h_active;
    logic           v_active;
    logic           h_wrap;
    logic           v_wrap;

    logic hsync_d, hsync_q;
    logic vsync_d, vsync_q;
    logic de_d, de_q;
    logic line_start_d, line_start_q;
    logic frame_start_d, frame_start_q;

    // Restart is only meaningful on enabled edges; gating it here keeps both
    // axes from jumping on a CE=0 edge.
    assign restart_ce = ce_i & restart_i;
    assign v_adv      = ce_i & h_wrap;

    timing_axis #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (H_POL),
        .W       (X_W)
    ) u_h_axis (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .adv_i        (ce_i),
        .restart_i    (restart_ce),
        .count_o      (h_count),
        .count_next_o (h_next),
        .sync_o       (h_sync),
        .active_o     (h_active),
        .wrap_o       (h_wrap)
    );

    timing_axis #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (V_POL),
        .W       (Y_W)
    ) u_v_axis (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .adv_i        (v_adv),
        .restart_i    (restart_ce),
        .count_o      (v_count),
        .count_next_o (v_next),
        .sync_o       (v_sync),
        .active_o     (v_active),
        .wrap_o       (v_wrap)
    );

    // The frame carry has no consumer at this level; the frame strobe is
    // decoded from the next counts instead.
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

    always_comb begin
        hsync_d       = h_sync;
        vsync_d       = v_sync;
        de_d          = h_active & v_active;
        line_start_d  = (h_next == '0);
        frame_start_d = (h_next == '0) && (v_next == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b1;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else if (ce_i) begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign x_o           = h_count;
    assign y_o           = v_count;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator
//   Three instances share one clock:
//   A: small custom mode, active-low syncs, random CE/RESTART/async reset
//   B: default 640x480 mode, CE=1 continuous
//   C: 800x600 package mode with active-high syncs, CE=1 continuous
//   Each is compared every clock against an (x,y) raster model.
module tb_vga_timing_generator;
    import vga_timing_pkg::*;

    localparam int A_HD = 10, A_HF = 3, A_HS = 4, A_HB = 5;
    localparam int A_VD = 6,  A_VF = 2, A_VS = 2, A_VB = 3;
    localparam int A_HT = A_HD + A_HF + A_HS + A_HB;
    localparam int A_VT = A_VD + A_VF + A_VS + A_VB;
    localparam int A_XW = count_width(A_HT);
    localparam int A_YW = count_width(A_VT);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, ce_a, restart_a;
    logic rst_bc, ce_bc, restart_bc;

    logic            hsync_a, vsync_a, de_a, ls_a, fs_a;
    logic [A_XW-1:0] x_a;
    logic [A_YW-1:0] y_a;
    logic            hsync_b, vsync_b, de_b, ls_b, fs_b;
    logic [10:0]     x_b;
    logic [9:0]      y_b;
    logic            hsync_c, vsync_c, de_c, ls_c, fs_c;
    logic [10:0]     x_c;
    logic [9:0]      y_c;

    vga_timing_generator #(
        .H_DISPLAY(A_HD), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_DISPLAY(A_VD), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
        .H_POL(1'b0), .V_POL(1'b0), .X_W(A_XW), .Y_W(A_YW)
    ) dut_a (
        .clk_i(clk), .rst_i(rst_a), .ce_i(ce_a), .restart_i(restart_a),
        .hsync_o(hsync_a), .vsync_o(vsync_a), .de_o(de_a), .x_o(x_a), .y_o(y_a),
        .line_start_o(ls_a), .frame_start_o(fs_a)
    );

    vga_timing_generator dut_b (
        .clk_i(clk), .rst_i(rst_bc), .ce_i(ce_bc), .restart_i(restart_bc),
        .hsync_o(hsync_b), .vsync_o(vsync_b), .de_o(de_b), .x_o(x_b), .y_o(y_b),
        .line_start_o(ls_b), .frame_start_o(fs_b)
    );

    vga_timing_generator #(
        .H_DISPLAY(SVGA800_H.display), .H_FRONT(SVGA800_H.front),
        .H_SYNC(SVGA800_H.sync), .H_BACK(SVGA800_H.back),
        .V_DISPLAY(SVGA800_V.display), .V_FRONT(SVGA800_V.front),
        .V_SYNC(SVGA800_V.sync), .V_BACK(SVGA800_V.back),
        .H_POL(1'b1), .V_POL(1'b1), .X_W(11), .Y_W(10)
    ) dut_c (
        .clk_i(clk), .rst_i(rst_bc), .ce_i(ce_bc), .restart_i(restart_bc),
        .hsync_o(hsync_c), .vsync_o(vsync_c), .de_o(de_c), .x_o(x_c), .y_o(y_c),
        .line_start_o(ls_c), .frame_start_o(fs_c)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // raster models: current position of each instance
    int mxa = 0, mya = 0, mxb = 0, myb = 0, mxc = 0, myc = 0;

    int fs_exp = 0, fs_last = -1;
    bit fs_a_prev = 1'b1;
    int b_last = -1, b_de = 0;
    int c_last = -1, c_hs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit exp_sync(input int c, input int start, input int width, input bit pol);
        return (c >= start && c < start + width) ? pol : !pol;
    endfunction

    task automatic adv(inout int mx, inout int my, input int ht, input int vt, input bit rs);
        if (rs) begin
            mx = 0;
            my = 0;
        end else begin
            mx++;
            if (mx == ht) begin
                mx = 0;
                my++;
                if (my == vt) my = 0;
            end
        end
    endtask

    task automatic check_dut(input string n, input logic [31:0] x, input logic [31:0] y,
                             input logic hs, input logic vs, input logic de,
                             input logic ls, input logic fs, input int mx, input int my,
                             input int hd, input int hf, input int hsw,
                             input int vd, input int vf, input int vsw,
                             input bit hp, input bit vp);
        chk({n, ".x"}, x, 32'(mx));
        chk({n, ".y"}, y, 32'(my));
        chk({n, ".hsync"}, 32'(hs), 32'(exp_sync(mx, hd + hf, hsw, hp)));
        chk({n, ".vsync"}, 32'(vs), 32'(exp_sync(my, vd + vf, vsw, vp)));
        chk({n, ".de"}, 32'(de), 32'((mx < hd) && (my < vd)));
        chk({n, ".line_start"}, 32'(ls), 32'(mx == 0));
        chk({n, ".frame_start"}, 32'(fs), 32'((mx == 0) && (my == 0)));
    endtask

    task automatic check_a();
        check_dut("A", 32'(x_a), 32'(y_a), hsync_a, vsync_a, de_a, ls_a, fs_a, mxa, mya,
                  A_HD, A_HF, A_HS, A_VD, A_VF, A_VS, 1'b0, 1'b0);
    endtask

    task automatic check_bc();
        check_dut("B", 32'(x_b), 32'(y_b), hsync_b, vsync_b, de_b, ls_b, fs_b, mxb, myb,
                  640, 16, 96, 480, 10, 2, 1'b0, 1'b0);
        check_dut("C", 32'(x_c), 32'(y_c), hsync_c, vsync_c, de_c, ls_c, fs_c, mxc, myc,
                  800, 40, 128, 600, 1, 4, 1'b1, 1'b1);
    endtask

    task automatic bookkeeping();
        if (fs_a && !fs_a_prev) begin
            if (fs_last >= 0 && fs_exp > 0)
                chk("A.frame_period", 32'(cyc - fs_last), 32'(fs_exp));
            fs_last = cyc;
        end
        fs_a_prev = fs_a;

        if (ls_b) begin
            if (b_last >= 0) begin
                chk("B.line_period", 32'(cyc - b_last), 32'd800);
                chk("B.de_per_line", 32'(b_de), 32'd640);
            end
            b_last = cyc;
            b_de   = 0;
        end
        if (de_b) b_de++;

        if (ls_c) begin
            if (c_last >= 0) begin
                chk("C.line_period", 32'(cyc - c_last), 32'd1056);
                chk("C.hsync_high_per_line", 32'(c_hs), 32'd128);
            end
            c_last = cyc;
            c_hs   = 0;
        end
        if (hsync_c) c_hs++;
    endtask

    task automatic clk_cycle(input bit ce_v, input bit rs_v, input bit a_in_rst);
        ce_a      = ce_v;
        restart_a = rs_v;
        @(posedge clk);
        if (!a_in_rst && ce_v) adv(mxa, mya, A_HT, A_VT, rs_v);
        adv(mxb, myb, 800, 525, 1'b0);
        adv(mxc, myc, 1056, 628, 1'b0);
        cyc++;
        #1;
        check_a();
        check_bc();
        bookkeeping();
    endtask

    // Assert reset between clock edges and check A before any edge arrives.
    task automatic do_reset();
        #3 rst_a = 1'b1;
        #1;
        mxa = 0;
        mya = 0;
        check_a();
        clk_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        #3 rst_a = 1'b0;
    endtask

    task automatic wait_for_a(input int tx, input int ty, input string tag);
        int k = 0;
        while (!(int'(x_a) == tx && int'(y_a) == ty) && k < 2 * A_HT * A_VT) begin
            clk_cycle(1'b1, 1'b0, 1'b0);
            k++;
        end
        chk(tag, 32'((int'(x_a) == tx) && (int'(y_a) == ty)), 32'd1);
    endtask

    initial begin
        rst_a      = 1'b1;
        rst_bc     = 1'b1;
        ce_a       = 1'b0;
        restart_a  = 1'b0;
        ce_bc      = 1'b1;
        restart_bc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_a();
        check_bc();
        #3;
        rst_a  = 1'b0;
        rst_bc = 1'b0;

        // CE held high: frame period is HT*VT clocks
        fs_exp  = A_HT * A_VT;
        fs_last = -1;
        repeat (700) clk_cycle(1'b1, 1'b0, 1'b0);

        // CE 1-in-4, with RESTART pulses on disabled edges that must be ignored
        fs_exp  = 4 * A_HT * A_VT;
        fs_last = -1;
        for (int i = 0; i < 2500; i++)
            clk_cycle((i % 4) == 3, ((i % 4) != 3) && ($urandom_range(0, 7) == 0), 1'b0);

        // random CE / RESTART with occasional async resets
        fs_exp = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0)
                do_reset();
            else
                clk_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0, 1'b0);
        end

        // directed restart mid-frame, then restart coinciding with frame wrap
        wait_for_a(18, 7, "A.reach_18_7");
        clk_cycle(1'b1, 1'b1, 1'b0);
        wait_for_a(A_HT - 1, A_VT - 1, "A.reach_last");
        clk_cycle(1'b1, 1'b1, 1'b0);
        clk_cycle(1'b1, 1'b0, 1'b0);
        clk_cycle(1'b0, 1'b1, 1'b0);

        // async reset while inside hsync on the last vsync line
        wait_for_a(A_HD + A_HF + 1, A_VD + A_VF + 1, "A.reach_in_sync");
        do_reset();
        repeat (300) clk_cycle(1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
